// File: rtl/register_file_sb.sv
// Integer register file with an integrated busy scoreboard; x0 always reads zero and is never busy.
// Optional `define WRITE_BYPASS_EN forwards same-cycle writeback data and busy-clear to the read ports.
module register_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_reg_write,
    input  logic [ADDR_W-1:0]        i_addr_des,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_alloc,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_addr_src,
    output logic [NUM_RD*DATA_W-1:0] o_data,
    output logic [NUM_RD-1:0]        o_src_busy,
    output logic [ADDR_W:0]          o_busy_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_hit, al_hit, cnt_inc, cnt_dec;

    // Reset gates the strobes so nothing pending leaks through the bypass while reset is held.
    assign wr_hit = i_reg_write && !i_rst && (i_addr_des != '0);
    assign al_hit = i_alloc && !i_rst && (i_alloc_addr != '0);

    // NOTE: the data array is reset on purpose: every register must read zero straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_hit) begin
            regs_q[i_addr_des] <= i_data;
        end
    end

    // NOTE: default first so no latch is inferred; blocking order lets alloc override the write clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) busy_d[i_addr_des]   = 1'b0;
        if (al_hit) busy_d[i_alloc_addr] = 1'b1;
    end

    assign cnt_inc = al_hit && !busy_q[i_alloc_addr];
    assign cnt_dec = wr_hit && busy_q[i_addr_des] && !(al_hit && (i_alloc_addr == i_addr_des));
    assign cnt_d   = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_busy_cnt = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] src;
        assign src = i_addr_src[k*ADDR_W +: ADDR_W];
`ifdef WRITE_BYPASS_EN
        logic byp;
        assign byp = wr_hit && (src == i_addr_des);
        assign o_data[k*DATA_W +: DATA_W] = byp ? i_data : regs_q[src];
        assign o_src_busy[k] = byp ? (al_hit && (i_alloc_addr == src)) : busy_q[src];
`else
        assign o_data[k*DATA_W +: DATA_W] = regs_q[src];
        assign o_src_busy[k] = busy_q[src];
`endif
    end
endmodule

// File: tb/tb_register_file_sb.sv
// Randomised and directed bench for register_file_sb against an array-based reference model.
// Build with +define+WRITE_BYPASS_EN to check the bypass variant.
module tb_register_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 2 ** AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              reg_write;
    logic [AW-1:0]     addr_des;
    logic [DW-1:0]     data;
    logic              alloc;
    logic [AW-1:0]     alloc_addr;
    logic [NR*AW-1:0]  addr_src;
    logic [NR*DW-1:0]  o_data;
    logic [NR-1:0]     o_src_busy;
    logic [AW:0]       o_busy_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];

    register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_reg_write (reg_write),
        .i_addr_des  (addr_des),
        .i_data      (data),
        .i_alloc     (alloc),
        .i_alloc_addr(alloc_addr),
        .i_addr_src  (addr_src),
        .o_data      (o_data),
        .o_src_busy  (o_src_busy),
        .o_busy_cnt  (o_busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge: write retires its producer, a later alloc re-marks busy.
    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            if (reg_write && addr_des != 0) begin
                m_reg[addr_des]  = data;
                m_busy[addr_des] = 1'b0;
            end
            if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NR*DW-1:0] ed;
        logic [NR-1:0]    eb;
        int               ec;
        ed = '0;
        eb = '0;
        ec = 0;
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic          b;
            a = addr_src[k*AW +: AW];
            d = m_reg[a];
            b = m_busy[a];
`ifdef WRITE_BYPASS_EN
            if (reg_write && addr_des != 0 && a == addr_des) begin
                d = data;
                b = alloc && (alloc_addr == a);
            end
`endif
            if (rst) begin
                d = '0;
                b = 1'b0;
            end
            ed[k*DW +: DW] = d;
            eb[k] = b;
        end
        for (int i = 0; i < DEPTH; i++) ec += int'(m_busy[i]);
        if (rst) ec = 0;
        check({tag, "_data"}, 64'(o_data), 64'(ed));
        check({tag, "_busy"}, 64'(o_src_busy), 64'(eb));
        check({tag, "_cnt"}, 64'(o_busy_cnt), 64'(ec));
    endtask

    task automatic half(input string tag);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        addr_des   = '0;
        data       = '0;
        alloc      = 1'b0;
        alloc_addr = '0;
        addr_src   = '0;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        model_clear();
        idle();
        rst = 1'b1;

        // Reset held with random traffic on every input.
        for (int c = 0; c < 3; c++) begin
            reg_write = 1'($urandom); addr_des = raddr(); data = $urandom;
            alloc = 1'($urandom); alloc_addr = raddr(); addr_src = {raddr(), raddr()};
            half("rst");
            check("rst_data0", 64'(o_data), 64'h0);
            check("rst_cnt0", 64'(o_busy_cnt), 64'h0);
            check("rst_busy0", 64'(o_src_busy), 64'h0);
            tick();
        end
        idle();
        rst = 1'b0;
        tick();

        // x0 ignores writes and allocations.
        reg_write = 1'b1; addr_des = 5'd0; data = 32'h12345678;
        half("x0w");
        tick();
        idle();
        half("x0r");
        check("x0_data", 64'(o_data[31:0]), 64'h0);
        alloc = 1'b1; alloc_addr = 5'd0;
        tick();
        idle();
        half("x0a");
        check("x0_busy", 64'(o_src_busy[0]), 64'h0);
        check("x0_cnt", 64'(o_busy_cnt), 64'h0);
        tick();

        // Write then read back.
        reg_write = 1'b1; addr_des = 5'd1; data = 32'h87654321; addr_src = {5'd0, 5'd1};
        half("wr1");
`ifdef WRITE_BYPASS_EN
        check("bypass_r1", 64'(o_data[31:0]), 64'h87654321);
`else
        check("nobypass_r1", 64'(o_data[31:0]), 64'h0);
`endif
        tick();
        addr_des = 5'd2; data = 32'hABCDEF01;
        half("wr2");
        tick();
        idle();
        addr_src = {5'd2, 5'd1};
        half("rd12");
        check("rd_r1r2", 64'(o_data), 64'hABCDEF01_87654321);
        tick();

        // Scoreboard counting.
        idle();
        alloc = 1'b1; alloc_addr = 5'd3;
        half("al3");
        tick();
        alloc_addr = 5'd4; addr_src = {5'd0, 5'd3};
        half("al4");
        check("sb_cnt1", 64'(o_busy_cnt), 64'd1);
        check("sb_r3busy", 64'(o_src_busy[0]), 64'd1);
        tick();
        alloc = 1'b0; reg_write = 1'b1; addr_des = 5'd3; data = 32'hAACCEE01;
        half("wr3");
        check("sb_cnt2", 64'(o_busy_cnt), 64'd2);
        tick();
        reg_write = 1'b0; alloc = 1'b1; alloc_addr = 5'd4; addr_src = {5'd4, 5'd3};
        half("real4");
        check("sb_cnt_after_wr", 64'(o_busy_cnt), 64'd1);
        check("sb_r3free", 64'(o_src_busy[0]), 64'd0);
        check("sb_r3data", 64'(o_data[31:0]), 64'hAACCEE01);
        tick();
        alloc = 1'b0;
        half("real4b");
        check("sb_waw_cnt", 64'(o_busy_cnt), 64'd1);
        check("sb_r4busy", 64'(o_src_busy[1]), 64'd1);
        tick();

        // Same-address and cross-address alloc/write collisions.
        idle();
        alloc = 1'b1; alloc_addr = 5'd5;
        half("al5");
        tick();
        reg_write = 1'b1; addr_des = 5'd5; data = 32'h11223344;
        half("col5");
        tick();
        idle();
        addr_src = {5'd0, 5'd5};
        half("col5r");
        check("col_data", 64'(o_data[31:0]), 64'h11223344);
        check("col_busy", 64'(o_src_busy[0]), 64'd1);
        check("col_cnt", 64'(o_busy_cnt), 64'd2);
        alloc = 1'b1; alloc_addr = 5'd6; reg_write = 1'b1; addr_des = 5'd5; data = 32'h55667788;
        tick();
        idle();
        addr_src = {5'd6, 5'd5};
        half("x56");
        check("x56_cnt", 64'(o_busy_cnt), 64'd2);
        check("x56_busy", 64'(o_src_busy), 64'b10);
        check("x56_data", 64'(o_data[31:0]), 64'h55667788);
        tick();

        // Fill r1..r7 then reset asynchronously between edges.
        for (int r = 1; r <= 7; r++) begin
            idle();
            alloc = 1'b1; alloc_addr = AW'(r);
            half("fill");
            tick();
        end
        idle();
        addr_src = {5'd2, 5'd1};
        half("full");
        check("full_cnt", 64'(o_busy_cnt), 64'd7);
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_cnt", 64'(o_busy_cnt), 64'd0);
        check("midrst_busy", 64'(o_src_busy), 64'd0);
        check("midrst_data", 64'(o_data), 64'd0);
        model_clear();
        tick();
        rst = 1'b0;
        tick();

        // Randomised traffic with addresses clustered to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            reg_write  = 1'($urandom);
            addr_des   = raddr();
            data       = $urandom;
            alloc      = 1'($urandom);
            alloc_addr = raddr();
            addr_src   = {raddr(), raddr()};
            half("rnd");
            tick();
        end
        rst = 1'b0;
        idle();
        half("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
